// File: rtl/pong_ctrl.sv
// pong_ctrl: game flow FSM for pong with BCD scoring, ball budget and
// frame-counted wait between balls and after game over.
module pong_ctrl #(
  parameter int FRAMES_WAIT = 120,
  parameter int BALLS_INIT  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn1,
  input  logic [1:0] btn2,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       miss,
  input  logic       hit_left,
  input  logic       hit_right,
  output logic       graph_still,
  output logic [7:0] score_left,
  output logic [7:0] score_right,
  output logic [1:0] balls_left,
  output logic [1:0] game_state
);
  localparam int TW = ($clog2(FRAMES_WAIT + 1) > 7) ? $clog2(FRAMES_WAIT + 1) : 7;
  typedef enum logic [1:0] {NEWGAME = 2'b00, PLAY = 2'b01, NEWBALL = 2'b10, OVER = 2'b11} state_t;
  state_t state_q, state_d;
  logic [7:0] sl_q, sl_d, sr_q, sr_d;
  logic [1:0] balls_q, balls_d;
  logic [TW-1:0] timer_q, timer_d;
  logic miss_q, hl_q, hr_q;
  logic refr_tick, timer_done, btn, miss_e, hl_e, hr_e;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v == 8'h99) ? v :
           (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction
  assign refr_tick  = (pix_y == 10'd481) && (pix_x == 10'd0);
  assign timer_done = (timer_q == '0);
  assign btn        = |{btn1, btn2};
  assign miss_e     = miss & ~miss_q;
  assign hl_e       = hit_left & ~hl_q;
  assign hr_e       = hit_right & ~hr_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= NEWGAME;
      sl_q    <= '0;
      sr_q    <= '0;
      balls_q <= 2'(BALLS_INIT);
      timer_q <= '0;
      miss_q  <= 1'b0;
      hl_q    <= 1'b0;
      hr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
      balls_q <= balls_d;
      timer_q <= timer_d;
      miss_q  <= miss;
      hl_q    <= hit_left;
      hr_q    <= hit_right;
    end
  end
  always_comb begin
    state_d = state_q;
    sl_d    = sl_q;
    sr_d    = sr_q;
    balls_d = balls_q;
    timer_d = (refr_tick && !timer_done) ? timer_q - TW'(1) : timer_q;
    case (state_q)
      NEWGAME: state_d = btn ? PLAY : NEWGAME;
      PLAY: begin
        if (miss_e) begin
          balls_d = balls_q - 2'd1;
          state_d = (balls_q > 2'd1) ? NEWBALL : OVER;
          timer_d = TW'(FRAMES_WAIT);
        end else begin
          sl_d = hl_e ? bcd_inc(sl_q) : sl_q;
          sr_d = hr_e ? bcd_inc(sr_q) : sr_q;
        end
      end
      NEWBALL: state_d = (timer_done && btn) ? PLAY : NEWBALL;
      OVER:    state_d = timer_done ? NEWGAME : OVER;
    endcase
    // entering or sitting in NEWGAME presents a fresh game immediately
    if (state_d == NEWGAME) begin
      sl_d    = '0;
      sr_d    = '0;
      balls_d = 2'(BALLS_INIT);
    end
  end
  always_comb begin
    graph_still = (state_q != PLAY);
    game_state  = state_q;
    score_left  = sl_q;
    score_right = sr_q;
    balls_left  = balls_q;
  end
endmodule

// File: tb/tb_pong_ctrl.sv
// tb_pong_ctrl: scenario tasks push expected snapshots to a scoreboard
// queue and pop/compare them against the DUT outputs.
module tb_pong_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] btn1 = '0, btn2 = '0;
  logic [9:0] pix_x = 10'd10, pix_y = 10'd0;
  logic miss = 1'b0, hit_left = 1'b0, hit_right = 1'b0;
  logic graph_still;
  logic [7:0] score_left, score_right;
  logic [1:0] balls_left, game_state;
  int passed = 0, total = 0;
  typedef struct {string name; logic [20:0] v;} exp_t;
  exp_t sb[$];
  exp_t e;
  logic [20:0] got;

  pong_ctrl #(.FRAMES_WAIT(2), .BALLS_INIT(3)) dut (
    .clk(clk), .reset(reset), .btn1(btn1), .btn2(btn2), .pix_x(pix_x), .pix_y(pix_y),
    .miss(miss), .hit_left(hit_left), .hit_right(hit_right), .graph_still(graph_still),
    .score_left(score_left), .score_right(score_right), .balls_left(balls_left),
    .game_state(game_state)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] snap(logic [1:0] gs, logic st, logic [7:0] sl, logic [7:0] sr, logic [1:0] b);
    return {gs, st, sl, sr, b};
  endfunction
  function automatic logic [7:0] to_bcd(int v);
    int m;
    m = (v > 99) ? 99 : v;
    return 8'(((m / 10) << 4) | (m % 10));
  endfunction
  function automatic logic [20:0] obs();
    return {game_state, graph_still, score_left, score_right, balls_left};
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic tick();
    pix_y = 10'd481; pix_x = 10'd0;
    step(1);
    pix_y = 10'd0; pix_x = 10'd10;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sb.push_back('{"reset_state", snap(2'b00, 1'b1, 8'h00, 8'h00, 2'd3)});
    step(2);
    reset = 1'b0;
    e = sb.pop_front(); got = obs(); total++;
    if (got !== e.v) $display("FAIL %s: got %h expected %h (state,still,sl,sr,balls)", e.name, got, e.v); else passed++;
    sb.push_back('{"idle_10_frames", snap(2'b00, 1'b1, 8'h00, 8'h00, 2'd3)});
    for (int i = 0; i < 10; i++) begin step(5); tick(); end
    e = sb.pop_front(); got = obs(); total++;
    if (got !== e.v) $display("FAIL %s: got %h expected %h (state,still,sl,sr,balls)", e.name, got, e.v); else passed++;
  endtask

  task automatic test_start_hold();
    btn1 = 2'b01;
    sb.push_back('{"start_play", snap(2'b01, 1'b0, 8'h00, 8'h00, 2'd3)});
    step(1);
    btn1 = 2'b00;
    e = sb.pop_front(); got = obs(); total++;
    if (got !== e.v) $display("FAIL %s: got %h expected %h (state,still,sl,sr,balls)", e.name, got, e.v); else passed++;
    hit_left = 1'b1;
    sb.push_back('{"held_hit_single_edge", snap(2'b01, 1'b0, 8'h01, 8'h00, 2'd3)});
    step(1000);
    hit_left = 1'b0;
    step(1);
    e = sb.pop_front(); got = obs(); total++;
    if (got !== e.v) $display("FAIL %s: got %h expected %h (state,still,sl,sr,balls)", e.name, got, e.v); else passed++;
  endtask

  task automatic test_saturate();
    for (int n = 1; n <= 101; n++) begin
      hit_right = 1'b1;
      if (n inside {9, 10, 99, 100, 101})
        sb.push_back('{$sformatf("score_right_after_%0d", n), snap(2'b01, 1'b0, 8'h01, to_bcd(n), 2'd3)});
      step(1);
      hit_right = 1'b0;
      step(1);
      if (n inside {9, 10, 99, 100, 101}) begin
        e = sb.pop_front(); got = obs(); total++;
        if (got !== e.v) $display("FAIL %s: got %h expected %h (state,still,sl,sr,balls)", e.name, got, e.v); else passed++;
      end
    end
  endtask

  task automatic test_both_hits();
    hit_left = 1'b1; hit_right = 1'b1;
    sb.push_back('{"both_hits", snap(2'b01, 1'b0, 8'h02, 8'h99, 2'd3)});
    step(1);
    hit_left = 1'b0; hit_right = 1'b0;
    step(1);
    e = sb.pop_front(); got = obs(); total++;
    if (got !== e.v) $display("FAIL %s: got %h expected %h (state,still,sl,sr,balls)", e.name, got, e.v); else passed++;
  endtask

  task automatic test_miss_with_hit();
    sb.push_back('{"score_left_05", snap(2'b01, 1'b0, 8'h05, 8'h99, 2'd3)});
    for (int i = 0; i < 3; i++) begin hit_left = 1'b1; step(1); hit_left = 1'b0; step(1); end
    e = sb.pop_front(); got = obs(); total++;
    if (got !== e.v) $display("FAIL %s: got %h expected %h (state,still,sl,sr,balls)", e.name, got, e.v); else passed++;
    miss = 1'b1; hit_left = 1'b1;
    sb.push_back('{"miss_beats_hit", snap(2'b10, 1'b1, 8'h05, 8'h99, 2'd2)});
    step(1);
    miss = 1'b0; hit_left = 1'b0;
    e = sb.pop_front(); got = obs(); total++;
    if (got !== e.v) $display("FAIL %s: got %h expected %h (state,still,sl,sr,balls)", e.name, got, e.v); else passed++;
  endtask

  task automatic test_newball_wait();
    btn2 = 2'b10;
    sb.push_back('{"newball_btn_before_ticks", snap(2'b10, 1'b1, 8'h05, 8'h99, 2'd2)});
    step(3);
    e = sb.pop_front(); got = obs(); total++;
    if (got !== e.v) $display("FAIL %s: got %h expected %h (state,still,sl,sr,balls)", e.name, got, e.v); else passed++;
    tick();
    sb.push_back('{"newball_after_one_tick", snap(2'b10, 1'b1, 8'h05, 8'h99, 2'd2)});
    step(3);
    e = sb.pop_front(); got = obs(); total++;
    if (got !== e.v) $display("FAIL %s: got %h expected %h (state,still,sl,sr,balls)", e.name, got, e.v); else passed++;
    tick();
    sb.push_back('{"newball_to_play", snap(2'b01, 1'b0, 8'h05, 8'h99, 2'd2)});
    step(1);
    btn2 = 2'b00;
    e = sb.pop_front(); got = obs(); total++;
    if (got !== e.v) $display("FAIL %s: got %h expected %h (state,still,sl,sr,balls)", e.name, got, e.v); else passed++;
  endtask

  task automatic test_game_over();
    miss = 1'b1; step(1); miss = 1'b0;
    btn1 = 2'b01;
    sb.push_back('{"restart_last_ball", snap(2'b01, 1'b0, 8'h05, 8'h99, 2'd1)});
    tick(); step(1); tick(); step(1);
    btn1 = 2'b00;
    e = sb.pop_front(); got = obs(); total++;
    if (got !== e.v) $display("FAIL %s: got %h expected %h (state,still,sl,sr,balls)", e.name, got, e.v); else passed++;
    miss = 1'b1;
    sb.push_back('{"last_miss_over", snap(2'b11, 1'b1, 8'h05, 8'h99, 2'd0)});
    step(1);
    miss = 1'b0;
    e = sb.pop_front(); got = obs(); total++;
    if (got !== e.v) $display("FAIL %s: got %h expected %h (state,still,sl,sr,balls)", e.name, got, e.v); else passed++;
    hit_left = 1'b1; step(1); hit_left = 1'b0;
    tick();
    sb.push_back('{"over_frozen", snap(2'b11, 1'b1, 8'h05, 8'h99, 2'd0)});
    step(2);
    e = sb.pop_front(); got = obs(); total++;
    if (got !== e.v) $display("FAIL %s: got %h expected %h (state,still,sl,sr,balls)", e.name, got, e.v); else passed++;
    tick();
    sb.push_back('{"over_to_newgame", snap(2'b00, 1'b1, 8'h00, 8'h00, 2'd3)});
    step(1);
    e = sb.pop_front(); got = obs(); total++;
    if (got !== e.v) $display("FAIL %s: got %h expected %h (state,still,sl,sr,balls)", e.name, got, e.v); else passed++;
  endtask

  task automatic test_reset_mid();
    btn1 = 2'b11; step(1); btn1 = 2'b00;
    miss = 1'b1;
    sb.push_back('{"second_game_newball", snap(2'b10, 1'b1, 8'h00, 8'h00, 2'd2)});
    step(1);
    miss = 1'b0;
    e = sb.pop_front(); got = obs(); total++;
    if (got !== e.v) $display("FAIL %s: got %h expected %h (state,still,sl,sr,balls)", e.name, got, e.v); else passed++;
    reset = 1'b1;
    sb.push_back('{"reset_in_newball", snap(2'b00, 1'b1, 8'h00, 8'h00, 2'd3)});
    step(1);
    reset = 1'b0;
    e = sb.pop_front(); got = obs(); total++;
    if (got !== e.v) $display("FAIL %s: got %h expected %h (state,still,sl,sr,balls)", e.name, got, e.v); else passed++;
  endtask

  initial begin
    test_reset();
    test_start_hold();
    test_saturate();
    test_both_hits();
    test_miss_with_hit();
    test_newball_wait();
    test_game_over();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
